// File: rtl/nem_ohmux_sel_ctrl.sv
// Select-line controller and two-way arbiter for the 2-input inverting NEM-relay one-hot mux.
// Enforces break-before-make dead time on release and an actuation settle time before grant.
module nem_ohmux_sel_ctrl #(
  parameter int ACTUATE_CYC = 4,
  parameter int RELEASE_CYC = 3,
  parameter int MAX_HOLD    = 0
) (
  input  logic CP,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  output logic S0,
  output logic S1,
  output logic GNT0,
  output logic GNT1,
  output logic BUSY
);

  if (ACTUATE_CYC < 1 || ACTUATE_CYC > 255) begin : g_bad_actuate
    $error("ACTUATE_CYC must be in 1..255");
  end
  if (RELEASE_CYC < 1 || RELEASE_CYC > 255) begin : g_bad_release
    $error("RELEASE_CYC must be in 1..255");
  end
  if (MAX_HOLD < 0 || MAX_HOLD > 65535) begin : g_bad_hold
    $error("MAX_HOLD must be in 0..65535");
  end

  typedef enum logic [1:0] {IDLE, ACTUATE, GRANTED, RELEASE} state_t;

  localparam logic [7:0]  ACT_LOAD   = 8'(ACTUATE_CYC - 1);
  localparam logic [7:0]  REL_LOAD   = 8'(RELEASE_CYC - 1);
  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);
  localparam logic        HOLD_ON    = (MAX_HOLD != 0);

  state_t      state;
  logic        owner;
  logic        last;
  logic [7:0]  cnt;
  logic [15:0] hold;

  logic any_req;
  logic pick;
  logic owner_req;
  logic other_req;
  logic revoke;

  // On a tie the requester that did not own the mux last time wins.
  always_comb begin
    any_req   = REQ0 | REQ1;
    pick      = (REQ0 & REQ1) ? ~last : REQ1;
    owner_req = owner ? REQ1 : REQ0;
    other_req = owner ? REQ0 : REQ1;
    revoke    = HOLD_ON & other_req & (hold >= HOLD_LIMIT);
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      hold  <= '0;
      S0    <= 1'b0;
      S1    <= 1'b0;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= ACTUATE;
            owner <= pick;
            last  <= pick;
            cnt   <= ACT_LOAD;
            S0    <= ~pick;
            S1    <= pick;
            BUSY  <= 1'b1;
          end
        end
        ACTUATE: begin
          // A request withdrawn mid-actuation still pays the full dead time.
          if (!owner_req) begin
            state <= RELEASE;
            cnt   <= REL_LOAD;
            S0    <= 1'b0;
            S1    <= 1'b0;
          end else if (cnt == 8'd0) begin
            state <= GRANTED;
            hold  <= '0;
            GNT0  <= ~owner;
            GNT1  <= owner;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GRANTED: begin
          if (!owner_req || revoke) begin
            state <= RELEASE;
            cnt   <= REL_LOAD;
            S0    <= 1'b0;
            S1    <= 1'b0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
          end else if (other_req && hold != 16'hFFFF) begin
            hold <= hold + 16'd1;
          end
        end
        RELEASE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (any_req) begin
            state <= ACTUATE;
            owner <= pick;
            last  <= pick;
            cnt   <= ACT_LOAD;
            S0    <= ~pick;
            S1    <= pick;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Directed bench for nem_ohmux_sel_ctrl: default instance plus a MAX_HOLD=8 instance,
// with a per-cycle monitor for one-hot selects, GNT=>S, dead time and settle time.
module tb_nem_ohmux_sel_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic s0, s1, gnt0, gnt1, busy;
  logic fb_req0, fb_req1;
  logic fb_s0, fb_s1, fb_gnt0, fb_gnt1, fb_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nem_ohmux_sel_ctrl dut (
    .CP(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
    .S0(s0), .S1(s1), .GNT0(gnt0), .GNT1(gnt1), .BUSY(busy)
  );

  nem_ohmux_sel_ctrl #(.MAX_HOLD(8)) dut_fair (
    .CP(clk), .RST(rst), .REQ0(fb_req0), .REQ1(fb_req1),
    .S0(fb_s0), .S1(fb_s1), .GNT0(fb_gnt0), .GNT1(fb_gnt1), .BUSY(fb_busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vectors are {S0,S1,GNT0,GNT1,BUSY}.
  task automatic expect_a(input string tag, input logic [4:0] exp);
    check(tag, 8'({s0, s1, gnt0, gnt1, busy}), 8'(exp));
  endtask

  task automatic expect_b(input string tag, input logic [4:0] exp);
    check(tag, 8'({fb_s0, fb_s1, fb_gnt0, fb_gnt1, fb_busy}), 8'(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Property monitor; tracking restarts after any reset edge since dead time is not kept across reset.
  logic rst_q = 1'b0;
  logic prev_sel = 1'b0;
  logic prev_g0 = 1'b0;
  logic prev_g1 = 1'b0;
  logic seen_high = 1'b0;
  int   low_run = 0;
  int   act0 = 0;
  int   act1 = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    check("onehot_s", 8'(s0 & s1), 8'd0);
    check("onehot_g", 8'(gnt0 & gnt1), 8'd0);
    check("gnt_implies_s", 8'((gnt0 & ~s0) | (gnt1 & ~s1)), 8'd0);
    check("fair_onehot", 8'((fb_s0 & fb_s1) | (fb_gnt0 & fb_gnt1)), 8'd0);
    check("fair_gnt_implies_s", 8'((fb_gnt0 & ~fb_s0) | (fb_gnt1 & ~fb_s1)), 8'd0);
    if (rst_q) begin
      seen_high = 1'b0;
      low_run   = 0;
      act0      = 0;
      act1      = 0;
    end else begin
      if (s0 | s1) begin
        if (!prev_sel && seen_high) check("dead_time", 8'(low_run >= 3), 8'd1);
        seen_high = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
      if (gnt0 && !prev_g0) check("settle0", 8'(act0 >= 4), 8'd1);
      if (gnt1 && !prev_g1) check("settle1", 8'(act1 >= 4), 8'd1);
      act0 = (s0 && !gnt0) ? act0 + 1 : (s0 ? act0 : 0);
      act1 = (s1 && !gnt1) ? act1 + 1 : (s1 ? act1 : 0);
    end
    prev_sel = s0 | s1;
    prev_g0  = gnt0;
    prev_g1  = gnt1;
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fb_req0 = 1'b0; fb_req1 = 1'b0;
    tick(2);
    expect_a("reset", 5'b00000);
    expect_b("reset_fair", 5'b00000);
    rst = 1'b0;
    tick(2);

    // Single request with default timing.
    req0 = 1'b1;
    tick(1); expect_a("t1_sel", 5'b10001);
    tick(3); expect_a("t1_settle", 5'b10001);
    tick(1); expect_a("t1_gnt", 5'b10101);
    tick(4); expect_a("t1_hold", 5'b10101);
    req0 = 1'b0;
    tick(1); expect_a("t1_rel", 5'b00001);
    tick(2); expect_a("t1_dead", 5'b00001);
    tick(1); expect_a("t1_idle", 5'b00000);

    // Tie straight after reset goes to requester 0, then hands over.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick(1); expect_a("t2_s0", 5'b10001);
    tick(4); expect_a("t2_g0", 5'b10101);
    tick(2);
    req0 = 1'b0;
    tick(1); expect_a("t2_rel", 5'b00001);
    tick(2); expect_a("t2_dead", 5'b00001);
    tick(1); expect_a("t2_s1", 5'b01001);
    tick(3); expect_a("t2_settle1", 5'b01001);
    tick(1); expect_a("t2_g1", 5'b01011);
    req1 = 1'b0;
    tick(1); expect_a("t2_rel1", 5'b00001);
    tick(3); expect_a("t2_idle", 5'b00000);

    // Abort during actuation.
    req1 = 1'b1;
    tick(1); expect_a("t3_s1", 5'b01001);
    tick(1); expect_a("t3_s1b", 5'b01001);
    req1 = 1'b0;
    tick(1); expect_a("t3_abort", 5'b00001);
    tick(2); expect_a("t3_dead", 5'b00001);
    tick(1); expect_a("t3_idle", 5'b00000);

    // Reset while requester 1 holds the grant.
    req1 = 1'b1;
    tick(5); expect_a("t5_g1", 5'b01011);
    req0 = 1'b1;
    rst  = 1'b1;
    tick(1); expect_a("t5_rst", 5'b00000);
    rst = 1'b0;
    tick(1); expect_a("t5_win0", 5'b10001);
    req0 = 1'b0; req1 = 1'b0;
    tick(6);

    // Fairness revoke on the MAX_HOLD=8 instance.
    do_reset();
    fb_req0 = 1'b1;
    tick(5); expect_b("f_g0", 5'b10101);
    tick(2);
    fb_req1 = 1'b1;
    tick(1); expect_b("f_wait", 5'b10101);
    tick(6); expect_b("f_hold7", 5'b10101);
    tick(1); expect_b("f_hold8", 5'b10101);
    tick(1); expect_b("f_revoke", 5'b00001);
    tick(2); expect_b("f_dead", 5'b00001);
    tick(1); expect_b("f_s1", 5'b01001);
    tick(3); expect_b("f_settle1", 5'b01001);
    tick(1); expect_b("f_g1", 5'b01011);
    tick(2);
    fb_req1 = 1'b0;
    tick(1); expect_b("f_rel1", 5'b00001);
    tick(2);
    tick(1); expect_b("f_regain", 5'b10001);
    tick(4); expect_b("f_regain_g0", 5'b10101);
    fb_req0 = 1'b0;

    // Random request stress; the monitor does the checking.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      tick(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(12);
    expect_a("stress_idle", 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nem_ohmux_sel_ctrl.md
# nem_ohmux_sel_ctrl

- Select-line controller and two-way arbiter for the 2-input, 8-bit inverting NEM-relay one-hot mux.
- Grants the shared mux to one of two requesters and drives the mux selects S0/S1.
- Relay timing rules:
  - Break-before-make: never both selects high, and a programmable dead time whenever the mux is released.
  - Actuation settle time before the grant, so the holder only samples ZN after the relay has closed.
- Sits beside each mux instance; the requesters drive the mux data inputs directly.

## Interface
Parameters:
- ACTUATE_CYC, 4, cycles from select assertion to grant; legal 1..255.
- RELEASE_CYC, 3, minimum cycles S0=S1=0 after any select drops; legal 1..255.
- MAX_HOLD, 0, fairness limit in cycles of GNT high while the other requester waits; 0 = unlimited; legal 0..65535.

Ports:
- CP  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ0  in  1  requester 0 wants the mux (drives I0_*); level, held until done.
- REQ1  in  1  requester 1 wants the mux (drives I1_*).
- S0  out  1  mux select 0, registered.
- S1  out  1  mux select 1, registered.
- GNT0  out  1  requester 0 owns the mux and ZN is settled, registered.
- GNT1  out  1  requester 1 owns the mux, registered.
- BUSY  out  1  state != IDLE, registered.

## Operation
- States: IDLE, ACTUATE, GRANTED, RELEASE. One owner register (0/1) and one round-robin pointer LAST (last owner).
- Down-counter: 8 bits, for ACTUATE/RELEASE. Hold counter: 16 bits, saturating.
- Reset: state IDLE; S0=S1=GNT0=GNT1=BUSY=0; LAST=1, so requester 0 wins the first tie.
- IDLE:
  - Only REQ0 or only REQ1 sampled high: that requester becomes owner.
  - Both high: the requester != LAST becomes owner.
  - Either case: go to ACTUATE, assert S_owner, set LAST=owner.
- ACTUATE:
  - S_owner high, GNT low, counting ACTUATE_CYC cycles.
  - Owner drops REQ before the count ends: abort to RELEASE; GNT never pulses.
  - Count ends with REQ still high: go to GRANTED, GNT_owner=1.
- GRANTED:
  - S_owner=GNT_owner=1 while REQ_owner is high.
  - Exit to RELEASE when REQ_owner is sampled low.
  - Also exit when MAX_HOLD!=0, the other REQ is high, and the hold counter has reached MAX_HOLD (revoke).
  - Exit action: S and GNT drop together on the next edge.
- RELEASE:
  - S0=S1=0 and GNT0=GNT1=0 for exactly RELEASE_CYC cycles.
  - Arbitration is evaluated on the edge ending the last RELEASE cycle, using the same rules as IDLE. That edge goes directly to ACTUATE if any REQ is high, else to IDLE.
- Invariants, every cycle:
  - S0&S1=0 and GNT0&GNT1=0.
  - GNT_k implies S_k.
  - Any select-low interval between two select-high intervals is ≥ RELEASE_CYC cycles.
- A revoked owner still holding REQ re-competes normally; LAST ensures the waiting requester wins first.
- The hold counter clears on entry to GRANTED and increments each GRANTED cycle while the other REQ is high.
- Out-of-range parameters are illegal; the implementation checks them at elaboration.

## Timing
- All outputs are registered; no combinational path from REQ to any output.
- REQ rise sampled at edge t in IDLE:
  - S_owner high from t+1.
  - GNT_owner high from t+1+ACTUATE_CYC.
  - BUSY high from t+1.
- REQ fall sampled at edge t in GRANTED: S and GNT low from t+1; the next select rises at the earliest at t+1+RELEASE_CYC.
- Handover with both requesting: owner A's REQ falls at edge t, so S_A is low from t+1 and S_B rises at t+1+RELEASE_CYC.
- Revoke: fires at the edge where the hold count equals MAX_HOLD. GNT is therefore high for exactly MAX_HOLD cycles while the other requester waits.
- RST high at any edge forces the reset values on the next cycle, from any state.
  - Mid-GRANTED reset drops S and GNT immediately; no dead-time guarantee across reset.
  - After RST falls, a new actuation must wait for a fresh IDLE arbitration.

## Test plan
- Single request, defaults: REQ0 high at edge 10 → S0=1 at cycle 11, GNT0=1 at 15; REQ0 low at 20 → S0=GNT0=0 at 21, BUSY=0 at 24.
- Tie after reset: REQ0=REQ1=1 at edge 5 → S0 at 6, GNT0 at 10; REQ0 low at 12 → S1 at 16, GNT1 at 20; S0&S1 never 1.
- Abort during actuation: REQ1 pulses high for cycles 3–4 → S1 high for cycles 4–5 (cut short), GNT1 never 1, S1=0 for ≥3 cycles, BUSY=0 after release.
- Fairness: MAX_HOLD=8, REQ0 held high forever, REQ1 rises while GNT0 is high → GNT0 high exactly 8 cycles after REQ1 is seen, 3 dead cycles, GNT1 at +4; REQ1 drop → requester 0 regains the mux.
- Reset mid-grant: RST=1 while GNT1=1 → next cycle all outputs 0 and state IDLE; with REQ0=REQ1=1 after RST falls, requester 0 wins.
- Random REQ stress: property checker confirms one-hot selects, GNT⇒S, dead time ≥RELEASE_CYC, and settle ≥ACTUATE_CYC before every GNT.
